// File: rtl/suma_ctrl.sv
// Keypad sequencer for the 3-digit BCD adder: operand entry, result latch, display select.
// Optional chained addition from SHOW is enabled by defining SUMA_CTRL_ACCUM_EN.
module suma_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] op_a,
  output logic [11:0] op_b,
  input  logic [15:0] sum_in,
  output logic [15:0] disp,
  output logic [1:0]  state,
  output logic        done,
  output logic        carry
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] op_a_q, op_a_d;
  logic [11:0] op_b_q, op_b_d;
  logic [1:0]  cnt_a_q, cnt_a_d;
  logic [1:0]  cnt_b_q, cnt_b_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        done_q, done_d;

  logic is_digit, is_plus, is_eq, is_clr;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_plus  = key_valid && (key_code == 4'hA);
  assign is_eq    = key_valid && (key_code == 4'hB);
  assign is_clr   = key_valid && (key_code == 4'hC);

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;

    case (state_q)
      ENTER_A: begin
        if (is_digit && cnt_a_q != 2'd3) begin
          op_a_d  = {op_a_q[7:0], key_code};
          cnt_a_d = cnt_a_q + 2'd1;
        end else if (is_plus) begin
          op_b_d  = 12'h000;
          cnt_b_d = 2'd0;
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        if (is_digit && cnt_b_q != 2'd3) begin
          op_b_d  = {op_b_q[7:0], key_code};
          cnt_b_d = cnt_b_q + 2'd1;
        end else if (is_eq) begin
          state_d = CALC;
        end
      end
      CALC: begin
        // Operands have been stable since entering CALC, so sum_in is settled here.
        result_d = sum_in;
        carry_d  = (sum_in[15:12] != 4'h0);
        done_d   = 1'b1;
        state_d  = SHOW;
      end
      SHOW: begin
        if (is_digit) begin
          op_a_d  = {8'h00, key_code};
          cnt_a_d = 2'd1;
          op_b_d  = 12'h000;
          cnt_b_d = 2'd0;
          state_d = ENTER_A;
        end
`ifdef SUMA_CTRL_ACCUM_EN
        else if (is_plus && !carry_q) begin
          op_a_d  = result_q[11:0];
          cnt_a_d = 2'd3;
          op_b_d  = 12'h000;
          cnt_b_d = 2'd0;
          state_d = ENTER_B;
        end
`endif
      end
      default: state_d = ENTER_A;
    endcase

    // Clear overrides everything except the one-cycle CALC step.
    if (is_clr && state_q != CALC) begin
      op_a_d   = 12'h000;
      op_b_d   = 12'h000;
      cnt_a_d  = 2'd0;
      cnt_b_d  = 2'd0;
      result_d = 16'h0000;
      carry_d  = 1'b0;
      state_d  = ENTER_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ENTER_A;
      op_a_q   <= 12'h000;
      op_b_q   <= 12'h000;
      cnt_a_q  <= 2'd0;
      cnt_b_q  <= 2'd0;
      result_q <= 16'h0000;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      ENTER_A:      disp = {4'h0, op_a_q};
      ENTER_B,CALC: disp = {4'h0, op_b_q};
      default:      disp = result_q;
    endcase
  end

  assign op_a  = op_a_q;
  assign op_b  = op_b_q;
  assign state = state_q;
  assign done  = done_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_suma_ctrl.sv
// Bench for suma_ctrl: decimal reference model plus a behavioural BCD adder on sum_in.
module tb_suma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] op_a, op_b;
  logic [15:0] sum_in, disp;
  logic [1:0]  state;
  logic        done, carry;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model: operands and result kept as decimal integers.
  int m_state, m_a, m_b, m_na, m_nb, m_res, m_done;

  localparam int S_A = 0, S_B = 1, S_CALC = 2, S_SHOW = 3;

  suma_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .op_a(op_a), .op_b(op_b), .sum_in(sum_in), .disp(disp),
    .state(state), .done(done), .carry(carry)
  );

  always #5 clk = ~clk;

  function automatic int from_bcd(logic [11:0] x);
    return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  assign sum_in = to_bcd(from_bcd(op_a) + from_bcd(op_b));

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_A; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_res = 0; m_done = 0;
  endtask

  task automatic model_step(logic v, logic [3:0] k);
    m_done = 0;
    if (m_state == S_CALC) begin
      m_res = m_a + m_b; m_done = 1; m_state = S_SHOW;
    end else if (v) begin
      if (k == 4'hC) begin
        m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_res = 0; m_state = S_A;
      end else if (k <= 4'd9) begin
        if (m_state == S_SHOW) begin
          m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_state = S_A;
        end
        if (m_state == S_A && m_na < 3) begin
          m_a = m_a * 10 + int'(k); m_na++;
        end else if (m_state == S_B && m_nb < 3) begin
          m_b = m_b * 10 + int'(k); m_nb++;
        end
      end else if (k == 4'hA) begin
        if (m_state == S_A) begin
          m_b = 0; m_nb = 0; m_state = S_B;
        end
`ifdef SUMA_CTRL_ACCUM_EN
        else if (m_state == S_SHOW && m_res < 1000) begin
          m_a = m_res; m_na = 3; m_b = 0; m_nb = 0; m_state = S_B;
        end
`endif
      end else if (k == 4'hB && m_state == S_B) begin
        m_state = S_CALC;
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_disp;
    case (m_state)
      S_A:           exp_disp = to_bcd(m_a);
      S_B, S_CALC:   exp_disp = to_bcd(m_b);
      default:       exp_disp = to_bcd(m_res);
    endcase
    check("state", {14'd0, state}, 16'(m_state));
    check("op_a", {4'h0, op_a}, to_bcd(m_a));
    check("op_b", {4'h0, op_b}, to_bcd(m_b));
    check("disp", disp, exp_disp);
    check("done", {15'd0, done}, 16'(m_done));
    check("carry", {15'd0, carry}, {15'd0, m_res >= 1000});
    if (done) done_cnt++;
  endtask

  // Called at a negedge: drive, let the edge happen, then compare at the next negedge.
  task automatic cycle(logic v, logic [3:0] k);
    key_valid = v;
    key_code  = k;
    @(posedge clk);
    model_step(v, k);
    @(negedge clk);
    key_valid = 1'b0;
    compare_all();
  endtask

  task automatic press(logic [3:0] k);
    cycle(1'b1, k);
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0);
  endtask

  task automatic enter_579();
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    press(4'h4); press(4'h5); press(4'h6); press(4'hB);
  endtask

  initial begin
    int d0;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", {14'd0, state}, 16'h0);
    check("rst_disp", disp, 16'h0);
    check("rst_done", {15'd0, done}, 16'h0);
    check("rst_carry", {15'd0, carry}, 16'h0);
    rst = 1'b0;
    idle();

    // 123 + 456
    enter_579();
    check("calc_state", {14'd0, state}, 16'd2);
    d0 = done_cnt;
    idle();
    check("show_done", {15'd0, done}, 16'h1);
    check("show_disp", disp, 16'h0579);
    check("show_op_a", {4'h0, op_a}, 16'h0123);
    check("show_op_b", {4'h0, op_b}, 16'h0456);
    check("show_carry", {15'd0, carry}, 16'h0);
    idle();
    check("done_once", 16'(done_cnt - d0), 16'd1);

    // Digit from SHOW starts a new operand A
    press(4'h7);
    check("new_a_state", {14'd0, state}, 16'd0);
    check("new_a_disp", disp, 16'h0007);
    check("new_a_op_b", {4'h0, op_b}, 16'h0);

    // '+' in SHOW
    press(4'hC);
    enter_579();
    idle(); idle();
    press(4'hA);
`ifdef SUMA_CTRL_ACCUM_EN
    check("acc_state", {14'd0, state}, 16'd1);
    press(4'h2); press(4'h1); press(4'hB); idle();
    check("acc_op_a", {4'h0, op_a}, 16'h0579);
    check("acc_op_b", {4'h0, op_b}, 16'h0021);
    check("acc_disp", disp, 16'h0600);
`else
    check("plus_show_state", {14'd0, state}, 16'd3);
    check("plus_show_disp", disp, 16'h0579);
`endif

    // 999 + 999
    press(4'hC);
    press(4'h9); press(4'h9); press(4'h9); press(4'hA);
    press(4'h9); press(4'h9); press(4'h9); press(4'hB);
    idle();
    check("big_disp", disp, 16'h1998);
    check("big_carry", {15'd0, carry}, 16'h1);
    press(4'hA);
    check("big_plus_state", {14'd0, state}, 16'd3);

    // Digit limit, clear, ignored codes
    press(4'hC);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("limit_op_a", {4'h0, op_a}, 16'h0123);
    press(4'hC);
    check("clr_op_a", {4'h0, op_a}, 16'h0);
    check("clr_state", {14'd0, state}, 16'd0);
    press(4'hE); press(4'hE);
    check("ign_disp", disp, 16'h0);

    // Reset during CALC
    press(4'h1); press(4'hA); press(4'h2); press(4'hB);
    check("pre_rst_state", {14'd0, state}, 16'd2);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_disp", disp, 16'h0);
    check("mid_rst_op_a", {4'h0, op_a}, 16'h0);
    check("mid_rst_state", {14'd0, state}, 16'h0);
    check("mid_rst_done", {15'd0, done}, 16'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(); idle();
    check("rst_no_done", 16'(done_cnt - d0), 16'd0);

    // Randomized key streams
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 99);
      if (r < 60)      k = 4'($urandom_range(0, 9));
      else if (r < 72) k = 4'hA;
      else if (r < 84) k = 4'hB;
      else if (r < 90) k = 4'hC;
      else             k = 4'($urandom_range(13, 15));
      cycle($urandom_range(0, 99) < 65, k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/suma_ctrl.md
# suma_ctrl

Sequencer for the 3-digit BCD adder: collects two operands from the keypad decoder as single-digit strokes, drives them onto the adder's operand inputs, latches the 4-digit BCD result and selects what the 7-segment display path shows. Sits between the keypad decoder (upstream, already debounced, one-cycle strobes) and the adder plus display multiplexer (downstream).

## Interface
- No parameters; all widths fixed (3 operand digits, 4 result digits).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0x0–0x9 digit, 0xA '+', 0xB '=', 0xC clear, 0xD–0xF ignored
- op_a  out  12  operand A to adder, {hundreds, tens, units}, registered
- op_b  out  12  operand B to adder, same packing, registered
- sum_in  in  16  adder result {thousands, hundreds, tens, units}, combinational from op_a/op_b
- disp  out  16  BCD digits to display path, {d3,d2,d1,d0}
- state  out  2  0 ENTER_A, 1 ENTER_B, 2 CALC, 3 SHOW
- done  out  1  one-cycle pulse when result latched
- carry  out  1  latched result thousands digit non-zero (sum ≥ 1000)

## Operation
- States: ENTER_A, ENTER_B, CALC, SHOW; registered, encoding as on `state`.
- Digit entry (ENTER_A → op_a, ENTER_B → op_b): operand ← {op[7:0], key_code}; new digit enters units, older digits shift up. Digit counter per operand; once 3 digits entered further digits are ignored (no shift, no wrap).
- ENTER_A: '+' → ENTER_B, clears op_b and its counter. '=' ignored.
- ENTER_B: '=' → CALC. '+' ignored.
- CALC: single cycle, all keys ignored; at end of cycle result ← sum_in, carry ← (sum_in[15:12] != 0), done=1 next cycle, → SHOW.
- SHOW: digit key → clears op_a, op_b, counters, enters that digit as first digit of A, → ENTER_A. '+' handled per Configuration. '=' ignored.
- Clear (0xC) in any state except CALC: op_a, op_b, counters, result, carry ← 0, → ENTER_A. Clear in CALC is ignored.
- Codes 0xD–0xF: ignored in every state. key_valid low: no state change.
- disp: ENTER_A → {4'h0, op_a}; ENTER_B and CALC → {4'h0, op_b}; SHOW → result.
- Operand digits are always 0–9 by construction; the block does not check sum_in for validity.

## Timing
- Reset values: state=ENTER_A, op_a=0, op_b=0, result=0, disp=0, done=0, carry=0, digit counters 0.
- A key strobed in cycle N updates op/state and is visible on outputs in cycle N+1.
- '=' accepted in cycle N: state=CALC at N+1; result, carry, state=SHOW, done=1 at N+2; done low at N+3.
- op_a/op_b are held stable from entry of CALC through SHOW, so sum_in is settled during CALC (combinational adder path must close in one clk period).
- At most one key per cycle; back-to-back strobes on consecutive cycles are each processed.
- Reset asserted mid-CALC: outputs go to reset values asynchronously; no done pulse.

## Configuration
- SUMA_CTRL_ACCUM_EN defined: in SHOW, '+' with carry=0 loads op_a ← result[11:0], marks A as 3 digits entered, clears op_b, → ENTER_B (chained addition). With carry=1, '+' is ignored.
- Undefined: '+' in SHOW is ignored; the only exits from SHOW are a digit or clear.

## Test plan
- Reset, keys 1,2,3,'+',4,5,6,'=' -> op_a=0x123, op_b=0x456, disp=0x0579 in SHOW, carry=0, one done pulse 2 cycles after '='.
- Keys 9,9,9,'+',9,9,9,'=' -> disp=0x1998, carry=1.
- Keys 1,2,3,4 -> op_a=0x123 (fourth digit ignored); then 0xC -> op_a=0, state=ENTER_A; 0xE strobes -> no change.
- In SHOW after 0x579, key 7 -> state=ENTER_A, op_a=0x007, op_b=0, disp=0x0007.
- With SUMA_CTRL_ACCUM_EN: after 0x579, '+',2,1,'=' -> op_a=0x579, op_b=0x021, disp=0x0600; after 0x1998, '+' -> state stays SHOW. Without macro: '+' in SHOW -> no change.
- Assert rst the cycle after '=' (during CALC) -> all outputs zero immediately, no done pulse, state=ENTER_A after release.
